// File: rtl/tracker_pkg.sv
// Shared tracker types.
//   tracker_entry_t : one trace entry as written into the circular log
//   ENTRY_W         : width of tracker_entry_t, the default log data width
//   LOG_ADDR_W      : default log address width, shared with the read path
package tracker_pkg;

  typedef struct packed {
    logic [3:0] src;
    logic [3:0] kind;
    logic [7:0] payload;
  } tracker_entry_t;

  localparam int unsigned ENTRY_W    = $bits(tracker_entry_t);
  localparam int unsigned LOG_ADDR_W = 4;

endpackage

// File: rtl/tracker_log_ram.sv
// Simple dual-port RAM: one write port and one read port.
// The read is synchronous and read-first, with a registered output.
// The data array has no reset, so it can map onto block RAM.
// Only the output register is reset.
//   clk, rst : clock; async active-high reset (output register only)
//   wr_en, wr_addr, wr_data : write port
//   rd_en, rd_addr          : read request, sampled on the clock edge
//   rd_data                 : registered read data; holds while rd_en is low
module tracker_log_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_addr] <= wr_data;
  end

  // Nonblocking update of mem gives read-first behaviour on an address collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rd_data <= '0;
    else if (rd_en)
      rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/tracker_log_buf.sv
// Circular trace log. It accepts one entry per cycle, stores the entry at
// curr_wr_addr and advances the pointer modulo 2^ADDR_W. It serves reads
// with a latency of one cycle. has_wrapped is sticky: it sets on the first
// pointer wrap and clears on log_clear or rst.
//   clk, rst                        : clock; async active-high reset
//   log_en                          : write enable gate
//   log_clear                       : pulse; clears pointer and wrap flag, and beats a write
//   log_wr_val, log_wr_data         : write entry
//   log_wr_rdy                      : always 1
//   log_rd_req_val, log_rd_req_addr : read request
//   log_rd_resp_val, log_rd_resp_data : read response, one cycle after the request
//   curr_wr_addr                    : next index to be written
//   has_wrapped                     : pointer has wrapped since the last clear
module tracker_log_buf
  import tracker_pkg::*;
#(
  parameter int DATA_W = ENTRY_W,
  parameter int ADDR_W = LOG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              log_en,
  input  logic              log_clear,
  input  logic              log_wr_val,
  input  logic [DATA_W-1:0] log_wr_data,
  output logic              log_wr_rdy,
  input  logic              log_rd_req_val,
  input  logic [ADDR_W-1:0] log_rd_req_addr,
  output logic              log_rd_resp_val,
  output logic [DATA_W-1:0] log_rd_resp_data,
  output logic [ADDR_W-1:0] curr_wr_addr,
  output logic              has_wrapped
);

  logic accept;

  assign log_wr_rdy = 1'b1;
  assign accept     = log_wr_val & log_en & ~log_clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      curr_wr_addr <= '0;
      has_wrapped  <= 1'b0;
    end else if (log_clear) begin
      curr_wr_addr <= '0;
      has_wrapped  <= 1'b0;
    end else if (accept) begin
      curr_wr_addr <= curr_wr_addr + 1'b1;
      if (curr_wr_addr == '1)
        has_wrapped <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      log_rd_resp_val <= 1'b0;
    else
      log_rd_resp_val <= log_rd_req_val;
  end

  tracker_log_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept),
    .wr_addr (curr_wr_addr),
    .wr_data (log_wr_data),
    .rd_en   (log_rd_req_val),
    .rd_addr (log_rd_req_addr),
    .rd_data (log_rd_resp_data)
  );

endmodule

// File: doc/tracker_log_buf.md
# tracker_log_buf

Circular log storage feeding the tracker read path. Accepts one fixed-width trace entry per cycle from the instrumented pipeline, stores it in a 2^ADDR_W-deep on-chip RAM, and serves single-entry reads to the NoC reader stage. Also exports the write pointer and wrap flag so the reader knows which entries are valid and where the oldest one lives.

## Interface
Parameters:
- DATA_W, -1, width of one log entry; equals the width of the tracker entry struct.
- ADDR_W, -1, log address width; depth = 2^ADDR_W.

Ports:
- clk  in  1  clock; the block uses this single clock.
- rst  in  1  reset, asynchronous, active-high.
- log_en  in  1  writes accepted only while high.
- log_clear  in  1  single-cycle pulse; resets the write pointer and the wrap flag.
- log_wr_val  in  1  entry present.
- log_wr_data  in  DATA_W  entry contents.
- log_wr_rdy  out  1  constant 1; the block never back-pressures writers.
- log_rd_req_val  in  1  read request.
- log_rd_req_addr  in  ADDR_W  entry index to read.
- log_rd_resp_val  out  1  read data valid.
- log_rd_resp_data  out  DATA_W  entry read.
- curr_wr_addr  out  ADDR_W  next index to be written.
- has_wrapped  out  1  sticky; set once the pointer has wrapped past 2^ADDR_W-1.

## Operation
- Write accept: log_wr_val & log_en & ~log_clear. On accept:
  - RAM[curr_wr_addr] <= log_wr_data.
  - curr_wr_addr <= curr_wr_addr + 1, modulo 2^ADDR_W.
- Entries not accepted are silently discarded; no counter.
- Wrap: an accept with curr_wr_addr == 2^ADDR_W-1 sets has_wrapped in the same edge as the pointer moves to 0. has_wrapped stays set until log_clear or rst.
- Valid entries:
  - has_wrapped = 0: indices [0, curr_wr_addr).
  - has_wrapped = 1: all indices; the oldest entry is at curr_wr_addr.
- Clear: log_clear sets curr_wr_addr to 0 and has_wrapped to 0 on the next edge.
  - Clear takes priority over a simultaneous write; that write is dropped.
  - RAM contents are not zeroed.
  - Reads in progress during a clear complete normally.
- Reads:
  - Every log_rd_req_val is served; there is no read-side ready.
  - Out-of-range addresses (beyond valid entries) return stale RAM contents. Range policing is the reader's job.

## Timing
- Reset values: curr_wr_addr 0, has_wrapped 0, log_rd_resp_val 0, log_rd_resp_data 0, log_wr_rdy 1. RAM contents are undefined after reset.
- Read latency is exactly 1 cycle:
  - Request sampled at edge t.
  - log_rd_resp_val is high, with data, for the single cycle following t.
  - Back-to-back requests give back-to-back responses.
- log_rd_resp_data holds its last value while log_rd_resp_val is low.
- Read-during-write to the same address in the same cycle returns the OLD contents (read-first).
- A write accepted at edge t is readable by a request sampled at edge t+1 or later.
- curr_wr_addr and has_wrapped are registered. They update on the edge that accepts the write, so the reader sees the new pointer one cycle after the write is offered.
- rst asserted mid-read kills any pending response: log_rd_resp_val is 0 immediately, and the request is lost.
- log_en changes take effect in the same cycle; there is no pipeline.

## Structure
- tracker_pkg holds:
  - the log entry struct typedef that sets DATA_W;
  - the default log ADDR_W localparam shared with the read path.
- Sub-module tracker_log_ram: simple dual-port RAM, 1 write / 1 read, synchronous read-first, registered output. It must infer block RAM and has no reset on the data array.
- Top level holds:
  - the write-pointer counter;
  - the wrap flag;
  - the accept/clear priority logic;
  - the response-valid register.

## Test plan
- Reset, then 5 writes 0xA0–0xA4 with log_en=1:
  - curr_wr_addr = 5, has_wrapped = 0.
  - Reads of addresses 0–4 return 0xA0–0xA4, each 1 cycle after its request.
- ADDR_W=3, write 10 entries (values 0–9):
  - has_wrapped rises on the 8th accept, and curr_wr_addr = 2 at the end.
  - addr0 reads 8, addr1 reads 9, addr2 reads 2.
- Write to addr 3 and read addr 3 in the same cycle:
  - response carries the old value;
  - a read on the next cycle carries the new value.
- log_clear pulsed together with log_wr_val after wrap:
  - curr_wr_addr = 0, has_wrapped = 0;
  - the write is dropped, and RAM[0] keeps its prior value.
- log_en=0 with 4 log_wr_val pulses: curr_wr_addr unchanged, and log_wr_rdy stays 1.
- Back-to-back reads of addresses 1, 2, 3 with rst asserted on the second response cycle:
  - log_rd_resp_val drops immediately;
  - all outputs return to reset values.
